// File: rtl/apb_rr_master_if.sv
// Requester handshake and APB bus bundle for the round-robin APB master.
interface apb_rr_master_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [31:0]           paddr;
    logic [31:0]           pwdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwdata, psel, penable, pwrite
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwdata, psel, penable, pwrite
    );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB
// register-file slave, rejecting illegal accesses without a bus cycle.
module apb_rr_master #(
    parameter int unsigned NUM_REQ  = 2,
    parameter logic [31:0] ADDR_MAX = 32'h10,
    parameter logic [31:0] RO_ADDR  = 32'h4
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_rr_master_if.master  bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick;
    logic               pick_valid;
    logic [31:0]        pick_addr;
    logic [31:0]        pick_wdata;
    logic               pick_write;
    logic               pick_err;
    logic               psel_d;
    logic               penable_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [31:0]        rsp_rdata_d;
    logic               rsp_err_d;

    // Round-robin search starting one past the last grant
    always_comb begin
        pick       = last_grant;
        pick_valid = 1'b0;
        cand       = last_grant;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
            if (!pick_valid && bus.req_valid[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Select the picked requester's payload and classify it
    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_addr  = bus.req_addr[32*i +: 32];
                pick_wdata = bus.req_wdata[32*i +: 32];
                pick_write = bus.req_write[i];
            end
        end
        pick_err = (pick_addr[1:0] != 2'b00) || (pick_addr > ADDR_MAX) ||
                   (pick_write && (pick_addr == RO_ADDR));
    end

    // State register; APB strobes flop alongside so reset clears them at once
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
        end else begin
            state       <= state_next;
            bus.psel    <= psel_d;
            bus.penable <= penable_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = pick_err ? ERR : SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: accept pulse plus next values of registered outputs
    always_comb begin
        bus.req_ready = '0;
        rsp_valid_d   = '0;
        rsp_rdata_d   = bus.rsp_rdata;
        rsp_err_d     = bus.rsp_err;
        psel_d        = (state_next == SETUP) || (state_next == ACCESS);
        penable_d     = (state_next == ACCESS);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (state == IDLE) && pick_valid && (pick == IDX_W'(i));
            rsp_valid_d[i]   = ((state == RESP) || (state == ERR)) && (grant == IDX_W'(i));
        end
        if (state == RESP) begin
            rsp_rdata_d = bus.pwrite ? 32'h0 : bus.prdata;
            rsp_err_d   = 1'b0;
        end else if (state == ERR) begin
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
        end
    end

    // Grant history, APB address/data latch and response registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant    <= IDX_W'(NUM_REQ - 1);
            grant         <= '0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.pwrite    <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            if ((state == IDLE) && pick_valid) begin
                grant      <= pick;
                last_grant <= pick;
                if (!pick_err) begin
                    bus.paddr  <= pick_addr;
                    bus.pwdata <= pick_wdata;
                    bus.pwrite <= pick_write;
                end
            end
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_rdata <= rsp_rdata_d;
            bus.rsp_err   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: APB register-file slave, transaction-level
// reference model with a per-cycle compare, directed and random stimulus.
module tb_apb_rr_master;
    localparam int unsigned N = 2;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    longint cyc   = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    apb_rr_master_if #(.NUM_REQ(N)) bus ();

    apb_rr_master #(.NUM_REQ(N), .ADDR_MAX(32'h10), .RO_ADDR(32'h4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic ceq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // APB register file slave: cntrl is 4 bits wide, reg1 read-only
    logic [31:0] slv_regs [5];
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            slv_regs[0] <= 32'h0;
            slv_regs[1] <= 32'h5A5A5555;
            slv_regs[2] <= 32'h12349876;
            slv_regs[3] <= 32'hA5A50000;
            slv_regs[4] <= 32'h0000FFFF;
            bus.prdata  <= 32'h0;
        end else if (bus.psel && bus.penable && bus.paddr <= 32'h10) begin
            if (bus.pwrite) begin
                if (bus.paddr == 32'h0) slv_regs[0] <= {28'h0, bus.pwdata[3:0]};
                else if (bus.paddr != 32'h4) slv_regs[bus.paddr[4:2]] <= bus.pwdata;
            end else begin
                bus.prdata <= slv_regs[bus.paddr[4:2]];
            end
        end
    end

    // Reference model: a timeline of scheduled bus and response events
    int          m_last;
    longint      m_free, m_setup, m_access, m_rsp;
    int          m_rsp_req;
    logic [31:0] m_rsp_data, m_rdata, m_paddr, m_pwdata;
    bit          m_rsp_err, m_err, m_pwrite;
    logic [31:0] m_regs [5];
    logic [N-1:0] e_valid, e_ready;

    task automatic model_reset();
        m_last   = N - 1;
        m_free   = 0;
        m_setup  = -1;
        m_access = -1;
        m_rsp    = -1;
        m_paddr  = 0;
        m_pwdata = 0;
        m_pwrite = 0;
        m_rdata  = 0;
        m_err    = 0;
        m_regs[0] = 32'h0;
        m_regs[1] = 32'h5A5A5555;
        m_regs[2] = 32'h12349876;
        m_regs[3] = 32'hA5A50000;
        m_regs[4] = 32'h0000FFFF;
    endtask

    task automatic model_accept(input int g);
        logic [31:0] a, wd;
        bit w;
        a  = bus.req_addr[32*g +: 32];
        wd = bus.req_wdata[32*g +: 32];
        w  = bus.req_write[g];
        if (a[1:0] == 2'b00 && a <= 32'h10 && !(w && a == 32'h4)) begin
            m_setup    = cyc + 1;
            m_access   = cyc + 2;
            m_rsp      = cyc + 4;
            m_free     = cyc + 4;
            m_rsp_err  = 0;
            m_rsp_data = w ? 32'h0 : m_regs[a[4:2]];
            if (w) m_regs[a[4:2]] = (a == 32'h0) ? (wd & 32'hF) : wd;
            m_paddr  = a;
            m_pwdata = wd;
            m_pwrite = w;
        end else begin
            m_rsp      = cyc + 2;
            m_free     = cyc + 2;
            m_rsp_err  = 1;
            m_rsp_data = 32'h0;
        end
        m_rsp_req = g;
        m_last    = g;
    endtask

    // Per-cycle compare of every DUT output against the model
    always @(negedge pclk) begin
        if (!presetn) begin
            model_reset();
        end else begin
            e_valid = '0;
            if (cyc == m_rsp) begin
                e_valid[m_rsp_req] = 1'b1;
                m_rdata = m_rsp_data;
                m_err   = m_rsp_err;
            end
            ceq("psel", 32'(bus.psel), 32'(cyc == m_setup || cyc == m_access));
            ceq("penable", 32'(bus.penable), 32'(cyc == m_access));
            ceq("paddr", bus.paddr, m_paddr);
            ceq("pwdata", bus.pwdata, m_pwdata);
            ceq("pwrite", 32'(bus.pwrite), 32'(m_pwrite));
            ceq("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
            ceq("rsp_rdata", bus.rsp_rdata, m_rdata);
            ceq("rsp_err", 32'(bus.rsp_err), 32'(m_err));
            e_ready = '0;
            if (cyc >= m_free) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (e_ready == '0 && bus.req_valid[c]) begin
                        e_ready[c] = 1'b1;
                        model_accept(c);
                    end
                end
            end
            ceq("req_ready", 32'(bus.req_ready), 32'(e_ready));
        end
    end

    // One request from requester r with literal expectations; call at posedge+1
    task automatic do_req(input int r, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e);
        longint t0, t1;
        bit got;
        t0 = 0;
        t1 = 0;
        bus.req_valid[r] = 1'b1;
        bus.req_write[r] = wr;
        bus.req_addr[32*r +: 32]  = a;
        bus.req_wdata[32*r +: 32] = wd;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge pclk);
            if (bus.req_ready[r]) begin
                got = 1;
                t0  = cyc;
            end
        end
        ceq("accept_seen", 32'(got), 32'd1);
        @(posedge pclk); #1;
        bus.req_valid[r] = 1'b0;
        @(negedge pclk);
        ceq("phase1_psel", 32'(bus.psel), 32'(!exp_e));
        ceq("phase1_penable", 32'(bus.penable), 32'd0);
        if (!exp_e) begin
            @(negedge pclk);
            ceq("access_strobes", {29'h0, bus.psel, bus.penable, bus.pwrite}, {29'h0, 1'b1, 1'b1, wr});
            ceq("access_paddr", bus.paddr, a);
        end
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge pclk);
            if (bus.rsp_valid[r]) begin
                got = 1;
                t1  = cyc;
            end
        end
        ceq("rsp_seen", 32'(got), 32'd1);
        ceq("rsp_latency", 32'(t1 - t0), exp_e ? 32'd2 : 32'd4);
        ceq("rsp_data", bus.rsp_rdata, exp_d);
        ceq("rsp_err_flag", 32'(bus.rsp_err), 32'(exp_e));
        @(posedge pclk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(9, 0))
            0: a = 32'h0;
            1: a = 32'h4;
            2: a = 32'h8;
            3: a = 32'hC;
            4: a = 32'h10;
            5: a = 32'h14;
            6: a = 32'h2;
            7: a = 32'h6;
            8: a = 32'h40;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    logic [N-1:0] exp_g, seen;
    bit any_rsp, got;

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        ceq("reset_psel_penable", {30'h0, bus.psel, bus.penable}, 32'h0);
        ceq("reset_paddr", bus.paddr, 32'h0);
        ceq("reset_pwdata", bus.pwdata, 32'h0);
        ceq("reset_rsp", {29'h0, bus.pwrite, bus.rsp_err, |bus.rsp_valid}, 32'h0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Reset values of the register file
        do_req(0, 0, 32'h4,  32'h0, 32'h5A5A5555, 0);
        do_req(0, 0, 32'h8,  32'h0, 32'h12349876, 0);
        do_req(0, 0, 32'hC,  32'h0, 32'hA5A50000, 0);
        do_req(0, 0, 32'h10, 32'h0, 32'h0000FFFF, 0);

        // Write then read back
        do_req(1, 1, 32'h8, 32'hDEADBEEF, 32'h0, 0);
        do_req(1, 0, 32'h8, 32'h0, 32'hDEADBEEF, 0);

        // Arbitration with both requesters continuously valid
        bus.req_write = '0;
        bus.req_addr[0 +: 32]  = 32'hC;
        bus.req_addr[32 +: 32] = 32'h10;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge pclk);
                if (bus.req_ready != '0) got = 1;
            end
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            ceq("arb_grant", 32'(bus.req_ready), 32'(exp_g));
            @(posedge pclk); #1;
        end
        bus.req_valid = '0;
        repeat (6) @(posedge pclk);
        #1;

        // Illegal accesses
        do_req(0, 1, 32'h4,  32'h12345678, 32'h0, 1);
        do_req(0, 0, 32'h14, 32'h0, 32'h0, 1);
        do_req(0, 0, 32'h6,  32'h0, 32'h0, 1);
        do_req(0, 0, 32'h4,  32'h0, 32'h5A5A5555, 0);

        // cntrl keeps only four bits
        do_req(1, 1, 32'h0, 32'hFFFFFFFF, 32'h0, 0);
        do_req(1, 0, 32'h0, 32'h0, 32'h0000000F, 0);

        // Reset asserted during ACCESS
        bus.req_write[0] = 1'b0;
        bus.req_addr[0 +: 32] = 32'h8;
        bus.req_valid[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge pclk);
            if (bus.req_ready[0]) got = 1;
        end
        ceq("midrst_accept", 32'(got), 32'd1);
        @(posedge pclk); #1;
        bus.req_valid[0] = 1'b0;
        @(posedge pclk); #2;
        ceq("midrst_in_access", {30'h0, bus.psel, bus.penable}, 32'h3);
        presetn = 1'b0;
        #1;
        ceq("midrst_strobes_cleared", {30'h0, bus.psel, bus.penable}, 32'h0);
        repeat (3) @(negedge pclk);
        #1;
        presetn = 1'b1;
        any_rsp = 0;
        repeat (6) begin
            @(negedge pclk);
            if (bus.rsp_valid != '0) any_rsp = 1;
        end
        ceq("midrst_no_rsp", 32'(any_rsp), 32'd0);
        @(posedge pclk); #1;
        bus.req_valid = 2'b11;
        @(negedge pclk);
        ceq("midrst_first_grant", 32'(bus.req_ready), 32'h1);
        @(posedge pclk); #1;
        bus.req_valid = '0;
        repeat (6) @(posedge pclk);
        #1;

        // Random traffic with holds, withdrawals and illegal addresses
        for (int c = 0; c < 600; c++) begin
            @(negedge pclk);
            seen = bus.req_ready;
            @(posedge pclk); #1;
            for (int r = 0; r < N; r++) begin
                if (seen[r] || !bus.req_valid[r]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        bus.req_valid[r] = 1'b1;
                        bus.req_write[r] = 1'($urandom_range(1, 0));
                        bus.req_addr[32*r +: 32]  = rand_addr();
                        bus.req_wdata[32*r +: 32] = $urandom;
                    end else begin
                        bus.req_valid[r] = 1'b0;
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    bus.req_valid[r] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
        repeat (8) @(posedge pclk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares the single APB register-file slave (cntrl at 0x0, reg1–reg4 at 0x4–0x10) between NUM_REQ requesters. It accepts one read or write request at a time, runs the APB setup and access phases, and captures the slave's read data. It then returns a response to the originating requester. Illegal accesses are rejected without touching the bus: unaligned addresses, out-of-map addresses, and writes to read-only reg1.

## Interface
- NUM_REQ, 2: number of requesters, from 2 to 8.
- ADDR_MAX, 32'h10: highest legal word address.
- RO_ADDR, 32'h4: read-only address. A write to it is an error.
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid; held until req_ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*32  packed addresses, requester i at [32*i +: 32]
- req_wdata  in  NUM_REQ*32  packed write data
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  response is an error
- paddr, pwdata  out  32  APB address and write data
- psel, penable, pwrite  out  1  APB controls
- prdata  in  32  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP, ERR.
- IDLE:
  - Pick a grant g from req_valid by round-robin. The search starts at last_grant+1, mod NUM_REQ.
  - req_ready[g]=1 in the same cycle, combinational from IDLE and req_valid. No other bit is set.
  - Latch addr, wdata and write for g. Set last_grant to g.
  - Go to ERR if any of these hold: addr[1:0]!=0, addr>ADDR_MAX, or (write and addr==RO_ADDR).
  - Otherwise go to SETUP. With no request, stay in IDLE.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from the latch. Go to ACCESS.
- ACCESS: psel=1, penable=1, same address and data. The slave has no pready, so ACCESS always lasts exactly one cycle. Go to RESP.
- RESP: psel=0, penable=0.
  - The slave's read data is valid on prdata in this cycle.
  - Register: rsp_rdata = write ? 0 : prdata, rsp_err=0, rsp_valid[g]=1.
  - Go to IDLE.
- ERR: no APB activity. Register rsp_rdata=0, rsp_err=1, rsp_valid[g]=1. Go to IDLE.
- rsp_valid, rsp_rdata and rsp_err are registered.
  - rsp_valid is a one-cycle pulse in the cycle after RESP or ERR, which is an IDLE cycle.
  - rsp_rdata and rsp_err hold their values until the next response.
- paddr, pwdata and pwrite are registered and hold their last values while psel=0.
- A requester must keep req_valid high until it sees req_ready. Dropping req_valid earlier withdraws the request, and that is legal.

## Timing
- Reset (asynchronous, presetn=0) drives:
  - state=IDLE;
  - psel, penable, pwrite = 0;
  - paddr, pwdata, rsp_rdata = 0;
  - rsp_valid=0, rsp_err=0;
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset during SETUP or ACCESS aborts the transfer. No response is ever issued for it.
- Legal transfer: accept in cycle T (IDLE). SETUP at T+1, ACCESS at T+2, RESP at T+3, rsp_valid at T+4.
- Error transfer: accept at T, ERR at T+1, rsp_valid at T+2.
- The cycle carrying rsp_valid is an IDLE cycle and can accept the next request. Legal back-to-back throughput is 1 transfer per 4 cycles; errors take 1 per 2.
- Grant fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- A request arriving during a busy transfer waits for IDLE. Arbitration looks only at the req_valid present in the IDLE cycle.

## Test plan
- Reset values: hold presetn=0, then release. Read 0x4, 0x8, 0xC, 0x10 from requester 0.
  - Required rsp_rdata: 5A5A5555, 12349876, A5A50000, 0000FFFF.
  - Required rsp_err=0 and rsp_valid[0] at T+4 each time.
- Write then read: requester 1 writes 0x8 = DEADBEEF, then reads 0x8.
  - Required: read returns DEADBEEF.
  - Required on the bus: SETUP with psel=1, penable=0, then ACCESS with psel=1, penable=1, pwrite=1.
- Arbitration: both requesters valid continuously for 6 transfers.
  - Required grants: 0,1,0,1,0,1, with no starvation.
  - Each response is routed to the rsp_valid bit of the requester that was granted.
- Errors: write 0x4, read 0x14, read 0x6.
  - Required: rsp_err=1 and rsp_rdata=0 for each, at T+2, with psel never asserted.
  - A following read of 0x4 still returns 5A5A5555.
- cntrl width: write 0x0 = FFFFFFFF, then read 0x0.
  - Required: rsp_rdata=0000000F.
- Mid-transfer reset: assert presetn=0 during ACCESS.
  - Required: psel=0 and penable=0 immediately, asynchronously.
  - Required: no rsp_valid pulse, and requester 0 is granted first after release.
